conv_line_span: RTL and testbench

//  Raster-to-column converter feeding the 5x5 convolution kernel assembler.

---
 rtl/conv_line_span.sv | 175 +++++++++++++++++
 tb/tb_conv_line_span.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/conv_line_span.sv
// Raster-to-column converter: keeps D-1 previous lines and emits one vertical
// D-pixel span per accepted pixel, then (D-1)/2 flush rows after end-of-frame.

module conv_line_span_row #(
  parameter int PIXEL_W = 8,
  parameter int DEPTH   = 64,
  parameter int AW      = 6
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [PIXEL_W-1:0] wdat_i,
  output logic [PIXEL_W-1:0] rdat_o
);
  logic [PIXEL_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdat_i;

  assign rdat_o = mem_q[addr_i];
endmodule

module conv_line_span #(
  parameter int PIXEL_W           = 8,
  parameter int KERNEL_DIAMETER_N = 5,
  parameter int IMG_W_MAX         = 64
) (
  input  logic                                   clk,
  input  logic                                   srst,
  input  logic                                   in_vld_i,
  output logic                                   in_rdy_o,
  input  logic [PIXEL_W-1:0]                     in_dat_i,
  input  logic                                   in_sof_i,
  input  logic                                   in_eol_i,
  input  logic                                   in_eof_i,
  output logic                                   colD_vld_o,
  output logic [KERNEL_DIAMETER_N-1:0]           colD_push_o,
  output logic [KERNEL_DIAMETER_N*PIXEL_W-1:0]   colD_dat_o,
  output logic [3:0]                             colD_pos_o,
  output logic                                   err_o
);
  localparam int D    = KERNEL_DIAMETER_N;
  localparam int CW   = $clog2(IMG_W_MAX);
  localparam int RW   = $clog2(D);
  localparam int HALF = (D - 1) / 2;
  localparam int FW   = $clog2(HALF + 1);
  localparam logic [CW-1:0] CMAX = CW'(IMG_W_MAX - 1);
  localparam logic [RW-1:0] RMAX = RW'(D - 1);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] c_q, c_d, wlast_q, wlast_d, c_eff, c_rd;
  logic [RW-1:0] rcnt_q, rcnt_d, rlast_q, rlast_d, rcnt_eff;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          wk_q, wk_d, ovf_q, ovf_d, wk_eff, rdy_q;
  logic          acc, drop, data_pix, wr_en;

  logic                         vld_q, vld_d, err_q, err_d;
  logic [D-1:0]                 push_q, push_d;
  logic [D-1:0][PIXEL_W-1:0]    dat_q, dat_d;
  logic [3:0]                   pos_q, pos_d;
  logic [D-2:0][PIXEL_W-1:0]    wr_line, rd_line;

  assign acc      = in_vld_i & rdy_q;
  // A sof pixel restarts the frame, so it sees cleared counters.
  assign c_eff    = in_sof_i ? '0 : c_q;
  assign rcnt_eff = in_sof_i ? '0 : rcnt_q;
  assign wk_eff   = in_sof_i ? 1'b0 : wk_q;
  assign drop     = ovf_q & ~in_sof_i;

  assign wr_line[0] = (state_q == FLUSH) ? '0 : in_dat_i;
  for (genvar k = 0; k < D-1; k++) begin : g_line
    if (k > 0) begin : g_chain
      assign wr_line[k] = rd_line[k-1];
    end
    conv_line_span_row #(.PIXEL_W(PIXEL_W), .DEPTH(IMG_W_MAX), .AW(CW)) u_row (
      .clk   (clk),
      .we_i  (wr_en),
      .addr_i(c_rd),
      .wdat_i(wr_line[k]),
      .rdat_o(rd_line[k])
    );
  end

  always_comb begin
    state_d = state_q; c_d = c_q; rcnt_d = rcnt_q; wlast_d = wlast_q; wk_d = wk_q;
    ovf_d = ovf_q; fcnt_d = fcnt_q; rlast_d = rlast_q;
    vld_d = 1'b0; push_d = '0; pos_d = '0; err_d = 1'b0; wr_en = 1'b0; c_rd = c_q;
    data_pix = 1'b0;
    unique case (state_q)
      IDLE: if (acc) begin
        if (in_sof_i) data_pix = 1'b1;
        else          err_d    = 1'b1;
      end
      FILL: if (acc) begin
        data_pix = 1'b1;
        err_d    = in_sof_i;
      end
      FLUSH: begin
        vld_d = 1'b1;
        wr_en = 1'b1;
        // Flush rows only carry real rows between r-fcnt and the kernel centre.
        for (int n = 1; n < D; n++)
          push_d[n] = (n >= int'(fcnt_q)) && (n <= HALF) && (n <= int'(rlast_q) + int'(fcnt_q));
        pos_d = {1'b0, c_q == '0, c_q == wlast_q, (fcnt_q == FW'(HALF)) && (c_q == wlast_q)};
        if (c_q == wlast_q) begin
          c_d = '0;
          if (fcnt_q == FW'(HALF)) state_d = IDLE;
          else                     fcnt_d  = fcnt_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (data_pix) begin
      c_rd = c_eff; c_d = c_eff; rcnt_d = rcnt_eff; wk_d = wk_eff; ovf_d = drop;
      state_d = FILL;
      if (drop) begin
        err_d = 1'b1;
      end else begin
        vld_d = 1'b1;
        wr_en = 1'b1;
        for (int n = 0; n < D; n++) push_d[n] = int'(rcnt_eff) >= n;
        pos_d = {in_sof_i, c_eff == '0, wk_eff ? (c_eff == wlast_q) : in_eol_i, 1'b0};
        if (in_eol_i && wk_eff && (c_eff != wlast_q)) err_d = 1'b1;
        if (!in_eol_i) begin
          if (c_eff == CMAX) ovf_d = 1'b1;
          else               c_d   = c_eff + 1'b1;
        end
      end
      if (in_eol_i) begin
        c_d    = '0;
        ovf_d  = 1'b0;
        rcnt_d = (rcnt_eff == RMAX) ? rcnt_eff : rcnt_eff + 1'b1;
        if (!wk_eff) begin
          wk_d    = 1'b1;
          wlast_d = drop ? CMAX : c_eff;
        end
        if (in_eof_i) begin
          state_d = FLUSH;
          fcnt_d  = FW'(1);
          rlast_d = rcnt_eff;
        end
      end
    end
  end

  // Rows not flagged in the push mask are zeroed so stale line data never leaks.
  always_comb begin
    dat_d[0] = push_d[0] ? in_dat_i : '0;
    for (int n = 1; n < D; n++) dat_d[n] = push_d[n] ? rd_line[n-1] : '0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE; c_q <= '0; rcnt_q <= '0; wlast_q <= '0; wk_q <= 1'b0;
      ovf_q <= 1'b0; fcnt_q <= '0; rlast_q <= '0; rdy_q <= 1'b0;
      vld_q <= 1'b0; push_q <= '0; dat_q <= '0; pos_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; c_q <= c_d; rcnt_q <= rcnt_d; wlast_q <= wlast_d; wk_q <= wk_d;
      ovf_q <= ovf_d; fcnt_q <= fcnt_d; rlast_q <= rlast_d; rdy_q <= (state_d != FLUSH);
      vld_q <= vld_d; push_q <= push_d; dat_q <= dat_d; pos_q <= pos_d; err_q <= err_d;
    end
  end

  assign in_rdy_o    = rdy_q;
  assign colD_vld_o  = vld_q;
  assign colD_push_o = push_q;
  assign colD_dat_o  = dat_q;
  assign colD_pos_o  = pos_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_conv_line_span.sv
// Directed bench for conv_line_span (D=5, 8-bit pixels, 64-pixel lines).

module tb_conv_line_span;
  localparam int PW = 8;
  localparam int D  = 5;

  logic            clk = 1'b0;
  logic            srst, in_vld_i, in_rdy_o, in_sof_i, in_eol_i, in_eof_i;
  logic [PW-1:0]   in_dat_i;
  logic            colD_vld_o, err_o;
  logic [D-1:0]    colD_push_o;
  logic [D*PW-1:0] colD_dat_o;
  logic [3:0]      colD_pos_o;

  int n_chk = 0;
  int n_fail = 0;

  conv_line_span #(.PIXEL_W(PW), .KERNEL_DIAMETER_N(D), .IMG_W_MAX(64)) dut (
    .clk(clk), .srst(srst), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_dat_i(in_dat_i),
    .in_sof_i(in_sof_i), .in_eol_i(in_eol_i), .in_eof_i(in_eof_i), .colD_vld_o(colD_vld_o),
    .colD_push_o(colD_push_o), .colD_dat_o(colD_dat_o), .colD_pos_o(colD_pos_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int base, input int w, input int r, input int c);
    return 8'(base + r*w + c);
  endfunction

  // Send pixel (r,c) of a clean frame and check the span that comes back.
  task automatic data_span(input int base, input int w, input int r, input int c, input bit last_row);
    logic [D-1:0]    ep;
    logic [D*PW-1:0] ed;
    in_vld_i = 1'b1; in_dat_i = pix(base, w, r, c);
    in_sof_i = (r == 0 && c == 0); in_eol_i = (c == w-1); in_eof_i = last_row && (c == w-1);
    step();
    ep = '0; ed = '0;
    for (int n = 0; n < D; n++)
      if (r >= n) begin ep[n] = 1'b1; ed[n*PW +: PW] = pix(base, w, r-n, c); end
    chk("data_vld", colD_vld_o, 1);
    chk("data_push", colD_push_o, ep);
    chk("data_dat", colD_dat_o, ed);
    chk("data_pos", colD_pos_o, {r == 0 && c == 0, c == 0, c == w-1, 1'b0});
    chk("data_err", err_o, 0);
  endtask

  // One flush cycle of flush row f at column c for a frame of h rows.
  task automatic flush_span(input int base, input int w, input int h, input int f, input int c);
    logic [D-1:0]    ep;
    logic [D*PW-1:0] ed;
    int rl;
    in_vld_i = 1'b0; in_sof_i = 1'b0; in_eol_i = 1'b0; in_eof_i = 1'b0;
    step();
    rl = (h-1 > D-1) ? D-1 : h-1;
    ep = '0; ed = '0;
    for (int n = 1; n < D; n++)
      if (n >= f && n <= 2 && n <= rl + f) begin
        ep[n] = 1'b1; ed[n*PW +: PW] = pix(base, w, h-1+f-n, c);
      end
    chk("flush_vld", colD_vld_o, 1);
    chk("flush_push", colD_push_o, ep);
    chk("flush_dat", colD_dat_o, ed);
    chk("flush_pos", colD_pos_o, {1'b0, c == 0, c == w-1, f == 2 && c == w-1});
    chk("flush_rdy", in_rdy_o, (f == 2 && c == w-1));
  endtask

  initial begin
    int lowcnt, eofcnt, nspan, ndrop;
    srst = 1'b1; in_vld_i = 1'b0; in_dat_i = '0; in_sof_i = 1'b0; in_eol_i = 1'b0; in_eof_i = 1'b0;
    step(); step(); step();
    chk("rst_vld", colD_vld_o, 0);
    chk("rst_rdy", in_rdy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_push", colD_push_o, 0);
    chk("rst_pos", colD_pos_o, 0);
    srst = 1'b0;
    step();
    chk("rdy_after_rst", in_rdy_o, 1);

    // 3x4 frame, pixels 0x01..0x0C
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        data_span(1, 4, r, c, r == 2);
        if (r == 0 && c == 2) chk("f1_row0_push", colD_push_o, 5'b00001);
        if (r == 2 && c == 0) chk("f1_row2_push", colD_push_o, 5'b00111);
        if (r == 2 && c == 1) chk("f1_span21", colD_dat_o, 40'h00_00_02_06_0A);
      end
    lowcnt = (in_rdy_o == 1'b0) ? 1 : 0;
    eofcnt = 0;
    for (int f = 1; f <= 2; f++)
      for (int c = 0; c < 4; c++) begin
        flush_span(1, 4, 3, f, c);
        if (c == 1) chk("f1_flush_push", colD_push_o, (f == 1) ? 5'b00110 : 5'b00100);
        if (!in_rdy_o) lowcnt++;
        if (colD_pos_o[0]) eofcnt++;
      end
    chk("f1_rdy_low_cycles", lowcnt, 8);
    chk("f1_eof_count", eofcnt, 1);

    // back-to-back frame, 2x4 from 0x40
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        data_span(64, 4, r, c, r == 1);
        if (r == 0 && c == 0) chk("f2_first_push", colD_push_o, 5'b00001);
        if (r == 0 && c == 2) chk("f2_no_stale", colD_dat_o, 40'h42);
      end
    for (int f = 1; f <= 2; f++)
      for (int c = 0; c < 4; c++) flush_span(64, 4, 2, f, c);

    // sof arriving at (1,2) restarts the frame; new width is 3
    for (int c = 0; c < 4; c++) data_span(128, 4, 0, c, 1'b0);
    for (int c = 0; c < 2; c++) data_span(128, 4, 1, c, 1'b0);
    in_vld_i = 1'b1; in_dat_i = 8'hA0; in_sof_i = 1'b1; in_eol_i = 1'b0; in_eof_i = 1'b0;
    step();
    chk("resof_err", err_o, 1);
    chk("resof_vld", colD_vld_o, 1);
    chk("resof_push", colD_push_o, 5'b00001);
    chk("resof_pos", colD_pos_o, 4'b1100);
    chk("resof_dat", colD_dat_o, 40'hA0);
    for (int c = 1; c < 3; c++) data_span(160, 3, 0, c, 1'b0);
    for (int c = 0; c < 3; c++) data_span(160, 3, 1, c, 1'b1);
    for (int f = 1; f <= 2; f++)
      for (int c = 0; c < 3; c++) flush_span(160, 3, 2, f, c);

    // srst in the middle of a flush
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) data_span(16, 4, r, c, r == 1);
    flush_span(16, 4, 2, 1, 0);
    flush_span(16, 4, 2, 1, 1);
    srst = 1'b1;
    step();
    chk("srst_vld", colD_vld_o, 0);
    chk("srst_rdy", in_rdy_o, 0);
    in_vld_i = 1'b1; in_dat_i = 8'h55;
    step();
    chk("srst_rdy_hold", in_rdy_o, 0);
    chk("srst_vld_hold", colD_vld_o, 0);
    chk("srst_err_hold", err_o, 0);
    srst = 1'b0; in_vld_i = 1'b0;
    step();
    chk("post_srst_rdy", in_rdy_o, 1);
    chk("post_srst_vld", colD_vld_o, 0);
    in_vld_i = 1'b1; in_dat_i = 8'h66;
    step();
    chk("nosof_err", err_o, 1);
    chk("nosof_vld", colD_vld_o, 0);
    in_vld_i = 1'b0;
    step();
    chk("nosof_err_pulse", err_o, 0);
    chk("nosof_vld_idle", colD_vld_o, 0);

    // full-width frame, then a 70-pixel line that overflows the line store
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 64; c++) data_span(0, 64, r, c, 1'b0);
    nspan = 0; ndrop = 0;
    for (int c = 0; c < 70; c++) begin
      in_vld_i = 1'b1; in_dat_i = (c < 64) ? pix(0, 64, 10, c) : 8'hEE;
      in_sof_i = 1'b0; in_eol_i = (c == 69); in_eof_i = 1'b0;
      step();
      if (colD_vld_o) nspan++;
      if (err_o) ndrop++;
      if (c == 63) chk("wide_c63_pos", colD_pos_o, 4'b0010);
      if (c == 63) chk("wide_c63_push", colD_push_o, 5'b11111);
    end
    chk("wide_spans", nspan, 64);
    chk("wide_drops", ndrop, 6);
    for (int c = 0; c < 64; c++) data_span(0, 64, 11, c, 1'b1);
    for (int f = 1; f <= 2; f++)
      for (int c = 0; c < 64; c++) flush_span(0, 64, 12, f, c);
    step();
    chk("end_vld", colD_vld_o, 0);
    chk("end_rdy", in_rdy_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
